score_table_ranker: RTL and testbench

//  Parametrised high-score table, successor to the fixed Scoring/Scoring_RAM pair.

---
 rtl/score_table_ranker_pkg.sv | 18 +
 rtl/score_table_ranker_bcd_gt.sv | 34 +++
 rtl/score_table_ranker.sv | 182 ++++++++++++++++++
 tb/tb_score_table_ranker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_table_ranker_pkg.sv
// Shared types and constants for the score_table_ranker high-score table.
package score_table_ranker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/score_table_ranker_bcd_gt.sv
// Combinational BCD compare (a > b, most significant digit first) plus a digit-range check on a.
module score_table_ranker_bcd_gt
    import score_table_ranker_pkg::*;
#(
    parameter int DIGITS = 2,
    localparam int SW    = 4 * DIGITS
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    output logic          a_gt_b,
    output logic          a_valid
);

    logic decided_s;

    // Walk digits from the top; the first unequal digit decides the order.
    always_comb begin
        a_gt_b    = 1'b0;
        a_valid   = 1'b1;
        decided_s = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            a_valid = a_valid & bcd_digit_ok(a[4*k +: 4]);
            if (!decided_s && (a[4*k +: 4] > b[4*k +: 4])) begin
                a_gt_b    = 1'b1;
                decided_s = 1'b1;
            end else if (!decided_s && (a[4*k +: 4] < b[4*k +: 4])) begin
                decided_s = 1'b1;
            end else begin
                decided_s = decided_s;
            end
        end
    end

endmodule

// File: rtl/score_table_ranker.sv
// Sorted high-score table: validated submissions are scanned in, the tail shifted down
// one entry per cycle, then written at their rank.
module score_table_ranker
    import score_table_ranker_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ID_W   = 3,
    parameter int DIGITS = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int SW    = 4 * DIGITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            sub_valid,
    output logic            sub_ready,
    input  logic [ID_W-1:0] sub_id,
    input  logic            sub_guest,
    input  logic [SW-1:0]   sub_score,
    output logic            sub_err,
    input  logic [AW-1:0]   rd_addr,
    output logic [ID_W-1:0] rd_id,
    output logic [SW-1:0]   rd_score,
    output logic            rd_hit,
    output logic [ID_W-1:0] top_id,
    output logic [SW-1:0]   top_score,
    output logic [AW:0]     count,
    output logic            busy
);

    state_t                     state_q, state_d;
    logic [AW-1:0]              idx_q, idx_d, pos_q, pos_d, idx_m1_s;
    logic [ID_W-1:0]            new_id_q, new_id_d;
    logic [SW-1:0]              new_score_q, new_score_d;
    logic                       new_guest_q, new_guest_d;
    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;
    logic [DEPTH-1:0][SW-1:0]   score_q, score_d;
    logic [AW:0]                count_q, count_d;
    logic                       sub_err_q, sub_err_d;
    logic [ID_W-1:0]            rd_id_q, rd_id_d;
    logic [SW-1:0]              rd_score_q, rd_score_d;
    logic                       rd_hit_q, rd_hit_d;
    logic                       new_gt_s, new_ok_s;

    // One comparator serves both the CHECK digit test and the SCAN ordering test.
    score_table_ranker_bcd_gt #(.DIGITS(DIGITS)) u_bcd_gt (
        .a       (new_score_q),
        .b       (score_q[idx_q]),
        .a_gt_b  (new_gt_s),
        .a_valid (new_ok_s)
    );

    assign idx_m1_s  = idx_q - AW'(1);
    assign sub_ready = rst & (state_q == ST_IDLE) & ~clear;
    assign busy      = (state_q != ST_IDLE);
    assign top_id    = id_q[0];
    assign top_score = score_q[0];
    assign count     = count_q;
    assign sub_err   = sub_err_q;
    assign rd_id     = rd_id_q;
    assign rd_score  = rd_score_q;
    assign rd_hit    = rd_hit_q;

    // Next-state logic for the FSM, the table and the read port.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pos_d       = pos_q;
        new_id_d    = new_id_q;
        new_score_d = new_score_q;
        new_guest_d = new_guest_q;
        valid_d     = valid_q;
        id_d        = id_q;
        score_d     = score_q;
        count_d     = count_q;
        sub_err_d   = 1'b0;
        rd_id_d     = id_q[rd_addr];
        rd_score_d  = score_q[rd_addr];
        rd_hit_d    = ({1'b0, rd_addr} < count_q);
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    valid_d = '0;
                    count_d = '0;
                end else if (sub_valid) begin
                    new_id_d    = sub_id;
                    new_score_d = sub_score;
                    new_guest_d = sub_guest;
                    state_d     = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (new_guest_q) begin
                    state_d = ST_IDLE;
                end else if (!new_ok_s) begin
                    sub_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Strict compare: an equal score keeps scanning, so it lands below the tie.
                if (!valid_q[idx_q] || new_gt_s) begin
                    pos_d = idx_q;
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_d = ST_WRITE;
                    end else begin
                        idx_d   = AW'(DEPTH - 1);
                        state_d = ST_SHIFT;
                    end
                end else if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_SHIFT: begin
                valid_d[idx_q] = valid_q[idx_m1_s];
                id_d[idx_q]    = id_q[idx_m1_s];
                score_d[idx_q] = score_q[idx_m1_s];
                if (idx_q == pos_q + AW'(1)) begin
                    state_d = ST_WRITE;
                end else begin
                    idx_d = idx_m1_s;
                end
            end
            ST_WRITE: begin
                valid_d[pos_q] = 1'b1;
                id_d[pos_q]    = new_id_q;
                score_d[pos_q] = new_score_q;
                if (count_q != (AW + 1)'(DEPTH)) begin
                    count_d = count_q + (AW + 1)'(1);
                end else begin
                    count_d = count_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and table registers; reset drops any in-flight submission.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pos_q       <= '0;
            new_id_q    <= '0;
            new_score_q <= '0;
            new_guest_q <= 1'b0;
            valid_q     <= '0;
            id_q        <= '0;
            score_q     <= '0;
            count_q     <= '0;
            sub_err_q   <= 1'b0;
            rd_id_q     <= '0;
            rd_score_q  <= '0;
            rd_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            new_id_q    <= new_id_d;
            new_score_q <= new_score_d;
            new_guest_q <= new_guest_d;
            valid_q     <= valid_d;
            id_q        <= id_d;
            score_q     <= score_d;
            count_q     <= count_d;
            sub_err_q   <= sub_err_d;
            rd_id_q     <= rd_id_d;
            rd_score_q  <= rd_score_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

endmodule

// File: tb/tb_score_table_ranker.sv
// Self-checking bench for score_table_ranker: directed vector table, random submissions
// against a sorted-list model, and hand-written clear/hold/reset sequences.
module tb_score_table_ranker;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       sub_valid;
    logic       sub_ready;
    logic [2:0] sub_id;
    logic       sub_guest;
    logic [7:0] sub_score;
    logic       sub_err;
    logic [1:0] rd_addr;
    logic [2:0] rd_id;
    logic [7:0] rd_score;
    logic       rd_hit;
    logic [2:0] top_id;
    logic [7:0] top_score;
    logic [2:0] count;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: ranked list of up to 4 (id, raw BCD score) pairs
    int         m_id[4];
    logic [7:0] m_sc[4];
    int         m_n;

    typedef struct {
        logic [2:0] id;
        logic [7:0] score;
        logic       guest;
        int         exp_busy;
        int         exp_err;
        int         exp_count;
        logic [7:0] exp_top;
    } vec_t;

    vec_t vecs[9];

    score_table_ranker #(.DEPTH(4), .ID_W(3), .DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sub_valid (sub_valid),
        .sub_ready (sub_ready),
        .sub_id    (sub_id),
        .sub_guest (sub_guest),
        .sub_score (sub_score),
        .sub_err   (sub_err),
        .rd_addr   (rd_addr),
        .rd_id     (rd_id),
        .rd_score  (rd_score),
        .rd_hit    (rd_hit),
        .top_id    (top_id),
        .top_score (top_score),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bcd_ok(input logic [7:0] s);
        return (s[7:4] <= 4'd9) && (s[3:0] <= 4'd9);
    endfunction

    function automatic int bcd_val(input logic [7:0] s);
        return int'(s[7:4]) * 10 + int'(s[3:0]);
    endfunction

    // Apply the ranking rules to the model; returns expected busy length and error flag.
    task automatic model_apply(input logic [2:0] id, input logic [7:0] sc, input logic guest,
                               output int exp_busy, output int exp_err);
        int p;
        exp_err = 0;
        if (guest) begin
            exp_busy = 1;
        end else if (!bcd_ok(sc)) begin
            exp_busy = 1;
            exp_err  = 1;
        end else begin
            p = m_n;
            for (int k = m_n - 1; k >= 0; k--)
                if (bcd_val(sc) > bcd_val(m_sc[k])) p = k;
            if (p >= 4) begin
                exp_busy = 5;
            end else begin
                for (int k = 3; k > p; k--) begin
                    m_id[k] = m_id[k-1];
                    m_sc[k] = m_sc[k-1];
                end
                m_id[p] = int'(id);
                m_sc[p] = sc;
                if (m_n < 4) m_n++;
                exp_busy = 6;
            end
        end
    endtask

    // Handshake one submission and measure how long busy stays high and any sub_err pulse.
    task automatic do_submit(input logic [2:0] id, input logic [7:0] sc, input logic guest,
                             output int nbusy, output int nerr);
        int n = 0;
        while (!sub_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_submit", int'(sub_ready), 1);
        sub_id    = id;
        sub_score = sc;
        sub_guest = guest;
        sub_valid = 1'b1;
        tick();
        sub_valid = 1'b0;
        nbusy = 0;
        nerr  = 0;
        while (busy && nbusy < 30) begin
            if (sub_err) nerr++;
            nbusy++;
            tick();
        end
        if (sub_err) nerr++;
        tick();
        if (sub_err) nerr++;
    endtask

    // Compare count, leader and every rank (through the read port) against the model.
    task automatic check_table(input string tag);
        check({tag, "_count"}, int'(count), m_n);
        if (m_n > 0) begin
            check({tag, "_top_id"}, int'(top_id), m_id[0]);
            check({tag, "_top_score"}, int'(top_score), int'(m_sc[0]));
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            tick();
            check({tag, "_rd_hit"}, int'(rd_hit), (a < m_n) ? 1 : 0);
            if (a < m_n) begin
                check({tag, "_rd_id"}, int'(rd_id), m_id[a]);
                check({tag, "_rd_score"}, int'(rd_score), int'(m_sc[a]));
            end
        end
    endtask

    task automatic do_clear();
        clear     = 1'b1;
        sub_valid = 1'b1;
        #1;
        check("clear_blocks_ready", int'(sub_ready), 0);
        tick();
        clear     = 1'b0;
        sub_valid = 1'b0;
        check("clear_not_accepted", int'(busy), 0);
        check("clear_count", int'(count), 0);
        m_n = 0;
    endtask

    initial begin
        int nb, ne, eb, ee, n;
        logic [2:0] rid;
        logic [7:0] rsc;
        logic       rg;
        int r;

        vecs[0] = '{3'd1, 8'h50, 1'b0, 6, 0, 1, 8'h50};
        vecs[1] = '{3'd2, 8'h72, 1'b0, 6, 0, 2, 8'h72};
        vecs[2] = '{3'd3, 8'h50, 1'b0, 6, 0, 3, 8'h72};
        vecs[3] = '{3'd4, 8'h31, 1'b0, 6, 0, 4, 8'h72};
        vecs[4] = '{3'd5, 8'h99, 1'b0, 6, 0, 4, 8'h99};
        vecs[5] = '{3'd6, 8'h40, 1'b0, 5, 0, 4, 8'h99};
        vecs[6] = '{3'd7, 8'h50, 1'b0, 5, 0, 4, 8'h99};
        vecs[7] = '{3'd0, 8'h99, 1'b1, 1, 0, 4, 8'h99};
        vecs[8] = '{3'd6, 8'h5A, 1'b0, 1, 1, 4, 8'h99};

        rst = 1'b0; clear = 1'b0; sub_valid = 1'b0; sub_id = '0;
        sub_guest = 1'b0; sub_score = '0; rd_addr = '0; m_n = 0;

        tick();
        tick();
        check("rst_ready", int'(sub_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        check("rst_top_score", int'(top_score), 0);
        check("rst_top_id", int'(top_id), 0);
        check("rst_rd_hit", int'(rd_hit), 0);
        check("rst_sub_err", int'(sub_err), 0);
        rst = 1'b1;
        #1;
        check("rst_release_ready", int'(sub_ready), 1);

        // Directed sequence from the ranking examples
        for (int i = 0; i < 9; i++) begin
            do_submit(vecs[i].id, vecs[i].score, vecs[i].guest, nb, ne);
            model_apply(vecs[i].id, vecs[i].score, vecs[i].guest, eb, ee);
            check($sformatf("vec%0d_busy", i), nb, vecs[i].exp_busy);
            check($sformatf("vec%0d_err", i), ne, vecs[i].exp_err);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("vec%0d_top", i), int'(top_score), int'(vecs[i].exp_top));
            check_table($sformatf("vec%0d", i));
        end

        do_clear();
        rd_addr = 2'd0;
        tick();
        check("clear_rd_hit", int'(rd_hit), 0);

        // Random submissions against the model, biased toward ties and bad digits
        for (int i = 0; i < 40; i++) begin
            rid = 3'($urandom_range(0, 7));
            r   = int'($urandom_range(0, 15));
            rg  = (r == 0);
            if (r <= 2)
                rsc = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 9))};
            else if (r == 3)
                rsc = {4'($urandom_range(0, 9)), 4'($urandom_range(10, 15))};
            else
                rsc = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 1) * 5)};
            do_submit(rid, rsc, rg, nb, ne);
            model_apply(rid, rsc, rg, eb, ee);
            check($sformatf("rnd%0d_busy", i), nb, eb);
            check($sformatf("rnd%0d_err", i), ne, ee);
            check_table($sformatf("rnd%0d", i));
        end

        // Hold sub_valid through a shifting insert; a clear while busy must be ignored
        do_clear();
        do_submit(3'd1, 8'h10, 1'b0, nb, ne);
        model_apply(3'd1, 8'h10, 1'b0, eb, ee);
        do_submit(3'd2, 8'h20, 1'b0, nb, ne);
        model_apply(3'd2, 8'h20, 1'b0, eb, ee);
        check_table("pre_hold");
        sub_id = 3'd3; sub_score = 8'h90; sub_guest = 1'b0; sub_valid = 1'b1;
        tick();
        clear = 1'b1;
        n = 0;
        while (busy && n < 30) begin
            check("hold_ready_low", int'(sub_ready), 0);
            tick();
            clear = 1'b0;
            n++;
        end
        check("hold_ready_back", int'(sub_ready), 1);
        sub_valid = 1'b0;
        model_apply(3'd3, 8'h90, 1'b0, eb, ee);
        check("hold_busy_len", n, eb);
        check_table("post_hold");

        // Reset in the middle of a shift
        sub_id = 3'd4; sub_score = 8'h95; sub_valid = 1'b1;
        tick();
        sub_valid = 1'b0;
        tick();
        tick();
        tick();
        check("midshift_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("midrst_count", int'(count), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(sub_ready), 0);
        check("midrst_top_id", int'(top_id), 0);
        check("midrst_top_score", int'(top_score), 0);
        check("midrst_rd_id", int'(rd_id), 0);
        check("midrst_rd_score", int'(rd_score), 0);
        check("midrst_rd_hit", int'(rd_hit), 0);
        check("midrst_sub_err", int'(sub_err), 0);
        tick();
        check("midrst_hold_ready", int'(sub_ready), 0);
        rst = 1'b1;
        #1;
        check("midrst_release_ready", int'(sub_ready), 1);
        m_n = 0;
        check_table("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
